morph3x3_stream: RTL and testbench

- Parametrised 3x3 grayscale/binary morphology filter for the camera pixel stream (DE2-115 capture path, after thresholding, before display/VGA).
- Runtime mode select: erosion (min), dilation (max) or pass-through, with proper image-border handling.
- Drains the final line internally through a flush state machine, so every accepted frame yields exactly IMG_W*IMG_H outputs in raster order.

---
 rtl/morph_pkg.sv | 25 ++
 rtl/morph_line_buffer.sv | 52 +++++
 rtl/morph3x3_stream.sv | 186 ++++++++++++++++++
 tb/tb_morph3x3_stream.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// morph_pkg: shared definitions for the 3x3 morphology stream filter.
//   - iMODE encodings (pass / erode / dilate)
//   - frame sequencing states
//   - neutral border value for a given mode and pixel width
package morph_pkg;

    localparam logic [1:0] MORPH_PASS   = 2'b00;
    localparam logic [1:0] MORPH_ERODE  = 2'b01;
    localparam logic [1:0] MORPH_DILATE = 2'b10;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } morph_state_e;

    // Value that can never win the min/max: all-ones for erode, zero otherwise.
    // Returned 64 bits wide; callers truncate to their pixel width.
    function automatic logic [63:0] morph_neutral(input logic [1:0] mode, input int data_w);
        logic [63:0] ones;
        ones = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        return (mode == MORPH_ERODE) ? ones : 64'd0;
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// morph_line_buffer: two cascaded IMG_W-deep line delays sharing one wrap pointer.
//   CLOCK, RESET_N : pixel clock, async active-low reset (pointer only)
//   i_en           : shift enable (one step per accepted or flushed pixel)
//   i_data         : incoming pixel
//   o_tap_mid      : pixel IMG_W steps old (previous line, same column)
//   o_tap_top      : pixel 2*IMG_W steps old (two lines back, same column)
// The RAM contents are not reset; border masking upstream hides stale data.
module morph_line_buffer #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_tap_mid,
    output logic [DATA_W-1:0] o_tap_top
);
    localparam int PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(IMG_W - 1);

    logic [DATA_W-1:0] line_mid_mem [IMG_W];
    logic [DATA_W-1:0] line_top_mem [IMG_W];
    logic [PW-1:0]     ptr_q, ptr_d;

    // Read-before-write at the same address gives exactly IMG_W steps of delay.
    assign o_tap_mid = line_mid_mem[ptr_q];
    assign o_tap_top = line_top_mem[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (i_en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (i_en) begin
            line_mid_mem[ptr_q] <= i_data;
            line_top_mem[ptr_q] <= o_tap_mid;
        end
    end

endmodule

// File: rtl/morph3x3_stream.sv
// morph3x3_stream: 3x3 erode/dilate/pass filter on a raster pixel stream.
//   CLOCK, RESET_N : pixel clock, async active-low reset
//   iDVAL, iSOF    : input valid, start of frame (qualified by iDVAL)
//   iDATA, iMODE   : input pixel, mode (00 pass, 01 erode, 10 dilate, 11 pass)
//   oDVAL, oDATA   : filtered pixel, registered, raster order
//   oBUSY          : draining the last line; inputs are refused
//   oDROP          : iDVAL seen while oBUSY
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_FILL  | first IMG_W+1 pixels of a frame, window not yet centred
// ST_RUN   | one output per accepted pixel
// ST_FLUSH | inputs refused, IMG_W+1 outputs drained with padded bottom
module morph3x3_stream
    import morph_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic [1:0]        iMODE,
    output logic              oDVAL,
    output logic [DATA_W-1:0] oDATA,
    output logic              oBUSY,
    output logic              oDROP
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    morph_state_e                state_q, state_d;
    logic [1:0]                  mode_q, mode_d;
    logic [CW-1:0]               in_col_q, in_col_d, ctr_col_q, ctr_col_d;
    logic [RW-1:0]               in_row_q, in_row_d, ctr_row_q, ctr_row_d;
    logic [2:0][2:0][DATA_W-1:0] win_q, win_d;   // [row][col], row 0 = oldest line, col 0 = left
    logic                        odval_q, odval_d;
    logic [DATA_W-1:0]           odata_q, odata_d;

    logic                        busy, accept, shift, emit, at_origin, at_run_entry, last_ctr;
    logic [DATA_W-1:0]           lb_in, tap_mid, tap_top, neutral, tap, res_min, res_max, result;
    logic [2:0][DATA_W-1:0]      col_new;

    morph_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buffer (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .i_en      (shift),
        .i_data    (lb_in),
        .o_tap_mid (tap_mid),
        .o_tap_top (tap_top)
    );

    // Window and min/max over the window as it will stand after this shift,
    // masked by the coordinates of the centre being emitted.
    always_comb begin
        busy    = (state_q == ST_FLUSH);
        accept  = iDVAL & ~busy;
        shift   = accept | busy;
        lb_in   = accept ? iDATA : '0;
        col_new = {lb_in, tap_mid, tap_top};

        win_d = win_q;
        if (shift) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
                win_d[r][2] = col_new[r];
            end
        end

        neutral = DATA_W'(morph_neutral(mode_q, DATA_W));
        res_min = '1;
        res_max = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                tap = win_d[r][c];
                if ((r == 0 && ctr_row_q == '0) || (r == 2 && ctr_row_q == ROW_LAST) ||
                    (c == 0 && ctr_col_q == '0) || (c == 2 && ctr_col_q == COL_LAST)) begin
                    tap = neutral;
                end
                if (tap < res_min) res_min = tap;
                if (tap > res_max) res_max = tap;
            end
        end

        case (mode_q)
            MORPH_ERODE:  result = res_min;
            MORPH_DILATE: result = res_max;
            default:      result = win_d[1][1];
        endcase
    end

    always_comb begin
        at_origin    = (in_col_q == '0) && (in_row_q == '0);
        at_run_entry = (in_col_q == COL_ONE) && (in_row_q == ROW_ONE);
        last_ctr     = (ctr_col_q == COL_LAST) && (ctr_row_q == ROW_LAST);
        // A restarting iSOF never emits: it would carry the aborted frame's centre.
        emit = busy | (accept & ~iSOF & ((state_q == ST_RUN) | at_run_entry));

        state_d   = state_q;
        mode_d    = mode_q;
        in_col_d  = in_col_q;
        in_row_d  = in_row_q;
        ctr_col_d = ctr_col_q;
        ctr_row_d = ctr_row_q;

        if (accept) begin
            if (iSOF) begin
                state_d   = ST_FILL;
                mode_d    = iMODE;
                in_col_d  = COL_ONE;
                in_row_d  = '0;
                ctr_col_d = '0;
                ctr_row_d = '0;
            end else begin
                if (at_origin) mode_d = iMODE;
                if (in_col_q == COL_LAST) begin
                    in_col_d = '0;
                    in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + ROW_ONE;
                end else begin
                    in_col_d = in_col_q + COL_ONE;
                end
                if (state_q == ST_FILL && at_run_entry) state_d = ST_RUN;
                if (state_q == ST_RUN && in_col_q == COL_LAST && in_row_q == ROW_LAST) state_d = ST_FLUSH;
            end
        end

        if (emit) begin
            if (ctr_col_q == COL_LAST) begin
                ctr_col_d = '0;
                ctr_row_d = (ctr_row_q == ROW_LAST) ? '0 : ctr_row_q + ROW_ONE;
            end else begin
                ctr_col_d = ctr_col_q + COL_ONE;
            end
        end

        if (busy && last_ctr) begin
            state_d  = ST_FILL;
            in_col_d = '0;
            in_row_d = '0;
        end

        odval_d = emit;
        odata_d = emit ? result : odata_q;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_FILL;
            mode_q    <= MORPH_PASS;
            in_col_q  <= '0;
            in_row_q  <= '0;
            ctr_col_q <= '0;
            ctr_row_q <= '0;
            win_q     <= '0;
            odval_q   <= 1'b0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            ctr_col_q <= ctr_col_d;
            ctr_row_q <= ctr_row_d;
            win_q     <= win_d;
            odval_q   <= odval_d;
            odata_q   <= odata_d;
        end
    end

    assign oDVAL = odval_q;
    assign oDATA = odata_q;
    assign oBUSY = busy;
    assign oDROP = iDVAL & busy;

endmodule

// File: tb/tb_morph3x3_stream.sv
// tb_morph3x3_stream: directed frame-level checks of morph3x3_stream on an 8x6 image.
module tb_morph3x3_stream;
    import morph_pkg::*;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       iDVAL = 1'b0;
    logic       iSOF = 1'b0;
    logic [9:0] iDATA = '0;
    logic [1:0] iMODE = MORPH_PASS;
    logic       oDVAL;
    logic [9:0] oDATA;
    logic       oBUSY;
    logic       oDROP;

    morph3x3_stream #(.DATA_W(10), .IMG_W(W), .IMG_H(H)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .iDVAL   (iDVAL),
        .iSOF    (iSOF),
        .iDATA   (iDATA),
        .iMODE   (iMODE),
        .oDVAL   (oDVAL),
        .oDATA   (oDATA),
        .oBUSY   (oBUSY),
        .oDROP   (oDROP)
    );

    always #5 CLOCK = ~CLOCK;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_n   = 0;
    int busy_n  = 0;
    int drop_n  = 0;
    logic [9:0] cap [64];

    typedef struct {
        int         pat;        // 0 single dot at (2,3), 1 all-ones with 0 at (0,0), 2 ramp col*16
        logic [1:0] mode;
        logic [1:0] alt_mode;   // iMODE driven from pixel switch_at onwards
        int         switch_at;
        bit         sof;
        bit         gaps;
        bit         hold;       // keep iDVAL high while oBUSY
        bit         check_lat;
        int         npix;
        logic [1:0] exp_mode;   // mode the frame must actually be filtered with
        int         exp_drops;
    } frame_t;

    frame_t tbl [5];

    always @(negedge CLOCK) begin
        if (oDVAL) begin
            if (cap_n < 64) cap[cap_n] = oDATA;
            cap_n = cap_n + 1;
        end
        if (oBUSY) busy_n = busy_n + 1;
        if (oDROP) drop_n = drop_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] pix(input int pat, input int k);
        int r = k / W;
        int c = k % W;
        case (pat)
            0:       return (r == 2 && c == 3) ? 10'h3FF : 10'h000;
            1:       return (r == 0 && c == 0) ? 10'h000 : 10'h3FF;
            default: return 10'(c * 16);
        endcase
    endfunction

    // Hand-derived results of each pattern under the mode it is used with.
    function automatic logic [9:0] exp_pix(input int pat, input logic [1:0] emode, input int i);
        int r = i / W;
        int c = i % W;
        case (pat)
            0: begin
                if (emode == MORPH_DILATE) return (r >= 1 && r <= 3 && c >= 2 && c <= 4) ? 10'h3FF : 10'h000;
                return 10'h000;
            end
            1:       return (r <= 1 && c <= 1) ? 10'h000 : 10'h3FF;
            default: return (c == 0) ? 10'h000 : 10'((c - 1) * 16);
        endcase
    endfunction

    task automatic run_frame(input frame_t rec, input string tag);
        int guard;
        for (int k = 0; k < rec.npix; k++) begin
            if (rec.gaps && k >= 10 && (k % 7) == 3) begin
                iDVAL = 1'b0;
                iSOF  = 1'b0;
                @(posedge CLOCK);
                @(negedge CLOCK);
                check($sformatf("%s gap_dval k=%0d", tag, k), int'(oDVAL), 0);
                check($sformatf("%s gap_hold k=%0d", tag, k), int'(oDATA), int'(exp_pix(rec.pat, rec.exp_mode, k - 10)));
                #1;
            end
            iDVAL = 1'b1;
            iSOF  = rec.sof && (k == 0);
            iDATA = pix(rec.pat, k);
            iMODE = (rec.switch_at >= 0 && k >= rec.switch_at) ? rec.alt_mode : rec.mode;
            @(posedge CLOCK);
            #1;
            iSOF  = 1'b0;
            iDVAL = (k == N - 1) ? rec.hold : 1'b0;
            if (k == 0) begin
                cap_n  = 0;
                busy_n = 0;
                drop_n = 0;
            end
            @(negedge CLOCK);
            if (k == 0) check({tag, " first_quiet"}, int'(oDVAL), 0);
            if (rec.check_lat && k == W) check({tag, " lat_before"}, int'(oDVAL), 0);
            if (rec.check_lat && k == W + 1) check({tag, " lat_first"}, int'(oDVAL), 1);
            #1;
        end
        if (rec.npix < N) return;

        guard = 0;
        while (oBUSY && guard < 40) begin
            @(posedge CLOCK);
            #1;
            guard++;
        end
        iDVAL = 1'b0;
        check({tag, " flush_done"}, int'(guard < 40), 1);
        repeat (2) @(posedge CLOCK);
        #1;
        check({tag, " out_count"}, cap_n, N);
        check({tag, " busy_cycles"}, busy_n, W + 1);
        check({tag, " drops"}, drop_n, rec.exp_drops);
        for (int i = 0; i < N && i < cap_n; i++) begin
            check($sformatf("%s pix(%0d,%0d)", tag, i / W, i % W), int'(cap[i]), int'(exp_pix(rec.pat, rec.exp_mode, i)));
        end
    endtask

    initial begin
        frame_t rec;

        tbl[0] = '{pat:0, mode:MORPH_DILATE, alt_mode:MORPH_DILATE, switch_at:-1, sof:1, gaps:0, hold:1,
                   check_lat:1, npix:N, exp_mode:MORPH_DILATE, exp_drops:W + 1};
        tbl[1] = '{pat:1, mode:MORPH_ERODE, alt_mode:MORPH_ERODE, switch_at:-1, sof:1, gaps:1, hold:0,
                   check_lat:0, npix:N, exp_mode:MORPH_ERODE, exp_drops:0};
        tbl[2] = '{pat:2, mode:MORPH_ERODE, alt_mode:MORPH_ERODE, switch_at:-1, sof:0, gaps:0, hold:1,
                   check_lat:1, npix:N, exp_mode:MORPH_ERODE, exp_drops:W + 1};
        tbl[3] = '{pat:0, mode:MORPH_ERODE, alt_mode:MORPH_DILATE, switch_at:20, sof:1, gaps:0, hold:0,
                   check_lat:0, npix:N, exp_mode:MORPH_ERODE, exp_drops:0};
        tbl[4] = '{pat:0, mode:MORPH_DILATE, alt_mode:MORPH_DILATE, switch_at:-1, sof:0, gaps:0, hold:0,
                   check_lat:0, npix:N, exp_mode:MORPH_DILATE, exp_drops:0};

        // Reset values
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst oDVAL", int'(oDVAL), 0);
        check("rst oDATA", int'(oDATA), 0);
        check("rst oBUSY", int'(oBUSY), 0);
        check("rst oDROP", int'(oDROP), 0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        #1;

        for (int t = 0; t < 5; t++) begin
            run_frame(tbl[t], $sformatf("frame%0d", t));
            repeat (3) @(posedge CLOCK);
            #1;
        end

        // Abort a ramp frame at pixel 30 with a new iSOF carrying a dilate frame.
        rec = tbl[2];
        rec.sof = 1;
        rec.npix = 30;
        run_frame(rec, "abort_part");
        rec = tbl[0];
        rec.hold = 0;
        rec.exp_drops = 0;
        run_frame(rec, "abort_new");
        repeat (3) @(posedge CLOCK);
        #1;

        // Reset in the middle of a frame: no flush afterwards.
        rec = tbl[2];
        rec.sof = 1;
        rec.npix = 20;
        run_frame(rec, "midrst_part");
        RESET_N = 1'b0;
        #1;
        check("midrst oDVAL", int'(oDVAL), 0);
        check("midrst oBUSY", int'(oBUSY), 0);
        check("midrst oDATA", int'(oDATA), 0);
        cap_n  = 0;
        busy_n = 0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (20) @(posedge CLOCK);
        #1;
        check("midrst no_outputs", cap_n, 0);
        check("midrst no_flush", busy_n, 0);
        run_frame(tbl[2], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
